// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: RV32I opcode constants, fetch FSM encoding
// and the text-segment base used as the reset PC.
package instruction_fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

   localparam logic [6:0] OPC_R_TYPE   = 7'b011_0011;
   localparam logic [6:0] OPC_I_LOGIC  = 7'b001_0011;
   localparam logic [6:0] OPC_I_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_I_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_U_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC_U_AUIPC  = 7'b001_0111;
   localparam logic [6:0] OPC_J_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_S_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_B_BRANCH = 7'b110_0011;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Loadable address register that comes out of reset at the text-segment base.
module pc_register
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] next_i,
   output logic [DATA_WIDTH-1:0] value_o
);

   logic [DATA_WIDTH-1:0] value_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= RESET_PC;
      end else if (load_i) begin
         value_q <= next_i;
      end
   end

   assign value_o = value_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake, squashes stale
// fetches on redirect and presents one registered instruction to decode.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  Imem_Req_o,
   output logic [DATA_WIDTH-1:0] Imem_Addr_o,
   input  logic                  Imem_Ack_i,
   input  logic [DATA_WIDTH-1:0] Imem_Rdata_i,
   input  logic                  Redirect_i,
   input  logic [DATA_WIDTH-1:0] Redirect_PC_i,
   output logic                  Instr_Valid_o,
   input  logic                  Instr_Ready_i,
   output logic [DATA_WIDTH-1:0] Instruction_o,
   output logic [6:0]            Opcode_o,
   output logic [DATA_WIDTH-1:0] PC_o,
   output logic [DATA_WIDTH-1:0] PC_Plus_4_o,
   output logic [31:0]           Instr_Count_o
);

   fetch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, addr_q;
   logic                  pc_load, addr_load, instr_load, count_inc, req;
   logic [DATA_WIDTH-1:0] instr_q, pc_out_q;
   logic [31:0]           count_q;
   logic [DATA_WIDTH-1:0] redirect_target;

   assign redirect_target = Redirect_PC_i & ~DATA_WIDTH'(3);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_load    = 1'b0;
      instr_load = 1'b0;
      count_inc  = 1'b0;
      req        = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            if (Redirect_i) begin
               pc_d    = redirect_target;
               pc_load = 1'b1;
            end
         end
         S_FETCH: begin
            req = 1'b1;
            if (Imem_Ack_i && !Redirect_i) begin
               instr_load = 1'b1;
               pc_d       = addr_q + DATA_WIDTH'(4);
               pc_load    = 1'b1;
               state_d    = S_HOLD;
            end else if (Redirect_i) begin
               pc_d    = redirect_target;
               pc_load = 1'b1;
               state_d = Imem_Ack_i ? S_FETCH : S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The in-flight request must complete; its data is thrown away.
            req = 1'b1;
            if (Redirect_i) begin
               pc_d    = redirect_target;
               pc_load = 1'b1;
            end
            if (Imem_Ack_i) begin
               state_d = S_FETCH;
            end
         end
         S_HOLD: begin
            count_inc = Instr_Ready_i;
            if (Redirect_i) begin
               pc_d    = redirect_target;
               pc_load = 1'b1;
            end
            if (Instr_Ready_i || Redirect_i) begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The fetch address only moves when a fresh FETCH begins, so it stays put while waiting.
   assign addr_load = (state_d == S_FETCH) && ((state_q != S_FETCH) || Imem_Ack_i);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         instr_q  <= '0;
         pc_out_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (instr_load) begin
            instr_q  <= Imem_Rdata_i;
            pc_out_q <= addr_q;
         end
         if (count_inc) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

   pc_register #(.DATA_WIDTH(DATA_WIDTH), .RESET_PC(RESET_PC)) u_pc (
      .clk     (clk),
      .reset   (reset),
      .load_i  (pc_load),
      .next_i  (pc_d),
      .value_o (pc_q)
   );

   pc_register #(.DATA_WIDTH(DATA_WIDTH), .RESET_PC(RESET_PC)) u_addr (
      .clk     (clk),
      .reset   (reset),
      .load_i  (addr_load),
      .next_i  (pc_d),
      .value_o (addr_q)
   );

   assign Imem_Req_o    = req;
   assign Imem_Addr_o   = addr_q;
   assign Instr_Valid_o = (state_q == S_HOLD);
   assign Instruction_o = instr_q;
   assign Opcode_o      = Instr_Valid_o ? instr_q[6:0] : 7'h00;
   assign PC_o          = pc_out_q;
   assign PC_Plus_4_o   = pc_out_q + DATA_WIDTH'(4);
   assign Instr_Count_o = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench: a variable-latency memory model, randomized redirects and
// back-pressure, and a program-order model of which PC decode should see next.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Imem_Req_o;
   logic [31:0] Imem_Addr_o;
   logic        Imem_Ack_i = 1'b0;
   logic [31:0] Imem_Rdata_i = '0;
   logic        Redirect_i = 1'b0;
   logic [31:0] Redirect_PC_i = '0;
   logic        Instr_Valid_o;
   logic        Instr_Ready_i = 1'b0;
   logic [31:0] Instruction_o;
   logic [6:0]  Opcode_o;
   logic [31:0] PC_o;
   logic [31:0] PC_Plus_4_o;
   logic [31:0] Instr_Count_o;

   instruction_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .Imem_Req_o    (Imem_Req_o),
      .Imem_Addr_o   (Imem_Addr_o),
      .Imem_Ack_i    (Imem_Ack_i),
      .Imem_Rdata_i  (Imem_Rdata_i),
      .Redirect_i    (Redirect_i),
      .Redirect_PC_i (Redirect_PC_i),
      .Instr_Valid_o (Instr_Valid_o),
      .Instr_Ready_i (Instr_Ready_i),
      .Instruction_o (Instruction_o),
      .Opcode_o      (Opcode_o),
      .PC_o          (PC_o),
      .PC_Plus_4_o   (PC_Plus_4_o),
      .Instr_Count_o (Instr_Count_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];   // redirect targets, pushed by the driver as issued
   int          min_wait = 0;
   int          max_wait = 0;
   int          wait_left = 0;
   bit          mem_busy = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == RESET_PC) return 32'h0000_0033;
      return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction memory: one request at a time, ack after a random wait.
   always @(negedge clk) begin
      if (reset) begin
         Imem_Ack_i = 1'b0;
         mem_busy   = 1'b0;
      end else begin
         Imem_Ack_i = 1'b0;
         if (Imem_Req_o) begin
            if (!mem_busy) begin
               mem_busy  = 1'b1;
               wait_left = $urandom_range(max_wait, min_wait);
            end
            if (wait_left == 0) begin
               Imem_Ack_i   = 1'b1;
               Imem_Rdata_i = mem_word(Imem_Addr_o);
               mem_busy     = 1'b0;
            end else begin
               wait_left--;
            end
         end
      end
   end

   // Monitor: program-order model of the next PC decode must be shown.
   logic [31:0] next_pc = RESET_PC;
   logic [31:0] cur_pc = '0;
   logic [31:0] cur_word = '0;
   logic [31:0] model_count = '0;
   bit          live = 0;
   bit          prev_req = 0;
   logic [31:0] prev_addr = '0;

   always @(posedge clk) begin
      #1;
      if (reset) begin
         live        = 0;
         model_count = '0;
         next_pc     = RESET_PC;
         prev_req    = 0;
      end else begin
         if (prev_req && !Imem_Ack_i) begin
            check("req_held", {31'b0, Imem_Req_o}, 32'd1);
            check("addr_held", Imem_Addr_o, prev_addr);
         end
         if (live && Instr_Ready_i) begin
            model_count = model_count + 32'd1;
            live = 0;
         end
         if (Redirect_i) begin
            live = 0;
            if (exp_q.size() == 0) begin
               check("redirect_queue", 32'd0, 32'd1);
            end else begin
               next_pc = exp_q.pop_front();
            end
         end
         if (Instr_Valid_o && !live) begin
            cur_pc   = next_pc;
            cur_word = mem_word(cur_pc);
            check("pc", PC_o, cur_pc);
            check("instr", Instruction_o, cur_word);
            check("pc_plus_4", PC_Plus_4_o, cur_pc + 32'd4);
            check("opcode", {25'b0, Opcode_o}, {25'b0, cur_word[6:0]});
            check("count", Instr_Count_o, model_count);
            next_pc = cur_pc + 32'd4;
            live = 1;
         end else if (live) begin
            check("hold_valid", {31'b0, Instr_Valid_o}, 32'd1);
            check("hold_instr", Instruction_o, cur_word);
            check("hold_pc", PC_o, cur_pc);
         end else begin
            check("opcode_idle", {25'b0, Opcode_o}, 32'd0);
         end
         if (Imem_Req_o) begin
            check("addr_align", {30'b0, Imem_Addr_o[1:0]}, 32'd0);
         end
         prev_req  = Imem_Req_o;
         prev_addr = Imem_Addr_o;
      end
   end

   task automatic step(input bit rd, input logic [31:0] tgt, input bit rdy);
      @(negedge clk);
      Redirect_i    = rd;
      Redirect_PC_i = tgt;
      Instr_Ready_i = rdy;
      if (rd) exp_q.push_back(tgt & ~32'd3);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input bit rdy);
      int n = 0;
      while (!Instr_Valid_o && n < 60) begin
         step(1'b0, '0, rdy);
         n++;
      end
      if (!Instr_Valid_o) check("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      check("rst_req", {31'b0, Imem_Req_o}, 32'd0);
      check("rst_valid", {31'b0, Instr_Valid_o}, 32'd0);
      check("rst_instr", Instruction_o, 32'd0);
      check("rst_opcode", {25'b0, Opcode_o}, 32'd0);
      check("rst_pc", PC_o, 32'd0);
      check("rst_pc4", PC_Plus_4_o, 32'd4);
      check("rst_count", Instr_Count_o, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      check("idle_req", {31'b0, Imem_Req_o}, 32'd0);

      // Zero-wait first fetch.
      step(1'b0, '0, 1'b0);
      check("first_req", {31'b0, Imem_Req_o}, 32'd1);
      check("first_addr", Imem_Addr_o, RESET_PC);
      step(1'b0, '0, 1'b0);
      check("first_valid", {31'b0, Instr_Valid_o}, 32'd1);
      check("first_opcode", {25'b0, Opcode_o}, 32'h33);
      check("first_pc4", PC_Plus_4_o, 32'h0040_0004);

      // Three wait states with decode always ready: five cycles per instruction.
      min_wait = 3;
      max_wait = 3;
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
      check("count_after_5", Instr_Count_o, 32'd5);
      check("addr_seq", Imem_Addr_o, 32'h0040_0014);

      // Redirect two cycles into the fetch: request drains at the old address.
      step(1'b0, '0, 1'b1);
      step(1'b1, 32'h0040_0100, 1'b1);
      check("drain_req", {31'b0, Imem_Req_o}, 32'd1);
      check("drain_addr", Imem_Addr_o, 32'h0040_0014);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      check("redirect_addr", Imem_Addr_o, 32'h0040_0100);

      // Back-pressure for five cycles, then squash with an unaligned target.
      min_wait = 0;
      max_wait = 0;
      wait_valid(1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
      step(1'b1, 32'h0040_0203, 1'b0);
      check("squash_valid", {31'b0, Instr_Valid_o}, 32'd0);
      check("squash_addr", Imem_Addr_o, 32'h0040_0200);

      // Fetch at the top of the address space and wrap.
      wait_valid(1'b0);
      step(1'b1, 32'hFFFF_FFFF, 1'b0);
      wait_valid(1'b0);
      check("wrap_pc4", PC_Plus_4_o, 32'd0);
      step(1'b0, '0, 1'b1);
      check("wrap_addr", Imem_Addr_o, 32'd0);

      // Randomized traffic.
      max_wait = 3;
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : (RESET_PC + ($urandom % 256));
         step(($urandom % 8) == 0, tgt, ($urandom % 4) != 0);
      end

      // Reset while a fetch is waiting on memory.
      min_wait = 3;
      max_wait = 3;
      begin
         int n = 0;
         while (!(Imem_Req_o && mem_busy) && n < 40) begin
            step(1'b0, '0, 1'b1);
            n++;
         end
         check("busy_fetch_seen", {31'b0, Imem_Req_o && mem_busy}, 32'd1);
      end
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("midrst_req", {31'b0, Imem_Req_o}, 32'd0);
      check("midrst_valid", {31'b0, Instr_Valid_o}, 32'd0);
      check("midrst_opcode", {25'b0, Opcode_o}, 32'd0);
      check("midrst_count", Instr_Count_o, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      min_wait = 0;
      max_wait = 2;
      step(1'b0, '0, 1'b1);
      check("restart_addr", Imem_Addr_o, RESET_PC);
      for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
